imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 64, datapath width of the immediate; legal values 32 and 64 only.
REQ-002 Parameter TAG_W, default 64, width of the sideband tag (PC) carried alongside each instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  ins/in_tag valid this cycle.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 ins  input  32  raw RISC-V instruction word.
REQ-009 in_tag  input  TAG_W  sideband tag, passed through unmodified.
REQ-010 out_valid  output  1  imm/fmt/illegal/out_tag valid.
REQ-011 out_ready  input  1  consumer accepts the output this cycle.
REQ-012 imm  output  XLEN  sign- or zero-extended immediate.
REQ-013 fmt  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z; 7 is never driven.
REQ-014 illegal  output  1  opcode not recognised.
REQ-015 out_tag  output  TAG_W  tag of the instruction currently presented.

Function
REQ-016 Decode SHALL use the full ins[6:0]: 0000011, 0010011, 1100111 -> I; 0011011 -> I if XLEN=64, otherwise illegal; 0100011 -> S; 1100011 -> B; 0110111 and 0010111 -> U; 1101111 -> J; 0110011 and 0111011 -> R with imm=0; 1110011 -> see REQ-031.
REQ-017 Any other opcode SHALL give illegal=1, imm=0 and fmt=0. The entry SHALL still be delivered through the handshake.
REQ-018 I-type SHALL give sext(ins[31:20]). Shift-amount opcodes SHALL NOT be special-cased.
REQ-019 S-type SHALL give sext({ins[31:25],ins[11:7]}).
REQ-020 B-type SHALL give sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}), a 13-bit value with bit 0 zero.
REQ-021 U-type SHALL give sext({ins[31:12],12'b0}) to XLEN.
REQ-022 J-type SHALL give sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
REQ-023 Every imm bit SHALL be driven in every case, with no latched or undefined bits.
REQ-024 Storage SHALL be a 2-entry skid buffer: output register plus skid register. Each entry holds {imm,fmt,illegal,tag,valid}.
REQ-025 Accept SHALL occur when in_valid && in_ready. Latency from accept to out_valid SHALL be exactly 1 cycle when the output register is empty or being drained that cycle.
REQ-026 in_ready SHALL equal !skid_valid, driven from registered state only with no combinational path from out_ready.
REQ-027 When an accept occurs while the output is stalled (out_valid && !out_ready), the entry SHALL go to the skid register. When the output drains, skid SHALL move to output before any new input.
REQ-028 Order SHALL be strictly FIFO, with no loss or duplication under any pattern of in_valid and out_ready.
REQ-029 Simultaneous accept and drain with the skid empty SHALL load the new entry directly into the output register.
REQ-030 flush SHALL clear both valid bits next cycle and take priority over a same-cycle accept, which is dropped. Payload registers SHALL be left unchanged.

Configuration
REQ-031 Macro IMM_GEN_CSR_EN. When defined, opcode 1110011 with funct3 of 101, 110 or 111 SHALL give fmt=6 and imm = zero-extended ins[19:15]; all other funct3 values SHALL give fmt=0 and imm=0. When undefined, every 1110011 encoding SHALL give fmt=0, imm=0, illegal=0.

Reset
REQ-032 On reset: out_valid=0, skid_valid=0, imm=0, fmt=0, illegal=0, out_tag=0, in_ready=1 from the first cycle after reset deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard both entries, and reset SHALL take priority over flush and accept.

Verification
REQ-034 ins=0xFFF00093, XLEN=64, out_ready=1 -> 1 cycle later imm=0xFFFFFFFFFFFFFFFF, fmt=1, illegal=0.
REQ-035 ins=0xFE000EE3 (beq -4) -> imm=0xFFFFFFFFFFFFFFFC, fmt=3; ins=0x800000B7 (lui) -> imm=0xFFFFFFFF80000000, fmt=4.
REQ-036 out_ready=0 with three back-to-back valids tagged 1,2,3 -> tags 1 and 2 accepted, in_ready=0 after the second. After out_ready=1, tags 1,2,3 emerge in order, one per cycle.
REQ-037 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushing-cycle input is never emitted.
REQ-038 ins=0x300FD073 -> with IMM_GEN_CSR_EN imm=31, fmt=6; without it imm=0, fmt=0. ins=0x0000007F -> illegal=1, imm=0. ins=0x0000001B at XLEN=32 -> illegal=1.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// The master drives instructions and consumes immediates; the slave is the decoder.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       ins;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   imm;
  logic [2:0]        fmt;
  logic              illegal;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, ins, in_tag, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal, out_tag
  );

  modport slave (
    input  in_valid, ins, in_tag, out_ready,
    output in_ready, out_valid, imm, fmt, illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a 2-entry skid buffer (output reg + skid reg).
// Optional macro IMM_GEN_CSR_EN decodes the zimm of CSRRWI/CSRRSI/CSRRCI as format Z.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  imm_gen_pipe_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
`ifdef IMM_GEN_CSR_EN
  localparam logic [2:0] FMT_Z = 3'd6;
`endif

  typedef struct packed {
    logic signed [XLEN-1:0] imm;
    logic [2:0]             fmt;
    logic                   illegal;
  } dec_t;

  function automatic logic signed [XLEN-1:0] sext12(input logic signed [11:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] sext13(input logic signed [12:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] sext21(input logic signed [20:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d.imm     = '0;
    d.fmt     = FMT_R;
    d.illegal = 1'b0;
    case (w[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        d.fmt = FMT_I;
        d.imm = sext12(w[31:20]);
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          d.fmt = FMT_I;
          d.imm = sext12(w[31:20]);
        end else begin
          d.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        d.fmt = FMT_S;
        d.imm = sext12({w[31:25], w[11:7]});
      end
      OP_BRANCH: begin
        d.fmt = FMT_B;
        d.imm = sext13({w[31], w[7], w[30:25], w[11:8], 1'b0});
      end
      OP_LUI, OP_AUIPC: begin
        d.fmt = FMT_U;
        d.imm = sext32({w[31:12], 12'b0});
      end
      OP_JAL: begin
        d.fmt = FMT_J;
        d.imm = sext21({w[31], w[19:12], w[20], w[30:21], 1'b0});
      end
      OP_REG, OP_REG32: begin
        d.fmt = FMT_R;
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
        // Only the immediate CSR forms (funct3 = 1xx, excluding 100) carry a zimm.
        if (w[14] && (w[13:12] != 2'b00)) begin
          d.fmt = FMT_Z;
          d.imm = XLEN'(w[19:15]);
        end
`endif
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  dec_t             dec_in;
  dec_t             dec_p0;
  dec_t             dec_p1;
  logic [TAG_W-1:0] tag_p0;
  logic [TAG_W-1:0] tag_p1;
  logic             vld_p0;
  logic             vld_p1;
  logic             accept;
  logic             load_p0;

  assign dec_in  = decode(bus.ins);
  assign accept  = bus.in_valid && !vld_p1;
  assign load_p0 = !vld_p0 || bus.out_ready;

  // p0 = output register, p1 = skid register; the skid always drains into p0 first
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      dec_p0 <= '0;
      tag_p0 <= '0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (load_p0) begin
      vld_p0 <= vld_p1 || accept;
      vld_p1 <= 1'b0;
      if (vld_p1) begin
        dec_p0 <= dec_p1;
        tag_p0 <= tag_p1;
      end else if (accept) begin
        dec_p0 <= dec_in;
        tag_p0 <= bus.in_tag;
      end
    end else if (accept) begin
      vld_p1 <= 1'b1;
      dec_p1 <= dec_in;
      tag_p1 <= bus.in_tag;
    end
  end

  assign bus.in_ready  = !vld_p1;
  assign bus.out_valid = vld_p0;
  assign bus.imm       = dec_p0.imm;
  assign bus.fmt       = dec_p0.fmt;
  assign bus.illegal   = dec_p0.illegal;
  assign bus.out_tag   = tag_p0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: vector table, handshake corner sequences,
// and a randomized run against a depth-2 FIFO reference model.
module tb_imm_gen_pipe;

  logic clk;
  logic reset;
  logic flush;

  imm_gen_pipe_if #(.XLEN(64), .TAG_W(64)) b64 ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(64)) b32 ();

  imm_gen_pipe #(.XLEN(64), .TAG_W(64)) dut64 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (b64)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(64)) dut32 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (b32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sgn(input longint raw, input int n);
    longint half;
    half = longint'(1) << (n - 1);
    return (raw >= half) ? raw - (half * 2) : raw;
  endfunction

  // Reference decode from the instruction-format rules, as plain integer arithmetic.
  function automatic exp_t model(input logic [31:0] w, input int xlen);
    exp_t   e;
    longint v;
    v     = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    e.tag = '0;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        e.fmt = 3'd1;
        v = sgn(longint'(w[31:20]), 12);
      end
      7'b0011011: begin
        if (xlen == 64) begin
          e.fmt = 3'd1;
          v = sgn(longint'(w[31:20]), 12);
        end else begin
          e.ill = 1'b1;
        end
      end
      7'b0100011: begin
        e.fmt = 3'd2;
        v = sgn(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
      end
      7'b1100011: begin
        e.fmt = 3'd3;
        v = sgn(longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4;
        v = sgn(longint'(w[31:12]) * 4096, 32);
      end
      7'b1101111: begin
        e.fmt = 3'd5;
        v = sgn(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
      end
      7'b0110011, 7'b0111011: e.fmt = 3'd0;
      7'b1110011: begin
`ifdef IMM_GEN_CSR_EN
        if (w[14:12] >= 3'd5) begin
          e.fmt = 3'd6;
          v = longint'(w[19:15]);
        end
`endif
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = (xlen == 64) ? 64'(v) : {32'h0, 32'(v)};
    return e;
  endfunction

  task automatic idle_inputs();
    b64.in_valid  = 1'b0;
    b64.ins       = '0;
    b64.in_tag    = '0;
    b64.out_ready = 1'b1;
    b32.in_valid  = 1'b0;
    b32.ins       = '0;
    b32.in_tag    = '0;
    b32.out_ready = 1'b1;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t        vecs[16];
  exp_t        e32;
  exp_t        q[$];
  exp_t        ne;
  logic [6:0]  ops[13];
  logic        fire_in;
  logic        fire_out;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    vecs[2]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
`ifdef IMM_GEN_CSR_EN
    vecs[3]  = '{32'h300FD073, 64'd31, 3'd6, 1'b0};
`else
    vecs[3]  = '{32'h300FD073, 64'd0, 3'd0, 1'b0};
`endif
    vecs[4]  = '{32'h0000007F, 64'd0, 3'd0, 1'b1};
    vecs[5]  = '{32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[6]  = '{32'hFE113C23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};
    vecs[7]  = '{32'h8000006F, 64'hFFFFFFFFFFF00000, 3'd5, 1'b0};
    vecs[8]  = '{32'h7FFFF06F, 64'h00000000000FFFFE, 3'd5, 1'b0};
    vecs[9]  = '{32'h00B50533, 64'd0, 3'd0, 1'b0};
    vecs[10] = '{32'h02B5053B, 64'd0, 3'd0, 1'b0};
    vecs[11] = '{32'h00001017, 64'h0000000000001000, 3'd4, 1'b0};
    vecs[12] = '{32'h7E000FE3, 64'h0000000000000FFE, 3'd3, 1'b0};
    vecs[13] = '{32'h7FF080E7, 64'h00000000000007FF, 3'd1, 1'b0};
    vecs[14] = '{32'h80003083, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0};
    vecs[15] = '{32'h34011073, 64'd0, 3'd0, 1'b0};
    ops = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
            7'h17, 7'h6F, 7'h33, 7'h3B, 7'h73, 7'h7F};

    do_reset();
    chk("rst_out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst_in_ready",  64'(b64.in_ready),  64'd1);
    chk("rst_imm",       b64.imm,            64'd0);
    chk("rst_fmt",       64'(b64.fmt),       64'd0);
    chk("rst_illegal",   64'(b64.illegal),   64'd0);
    chk("rst_out_tag",   b64.out_tag,        64'd0);

    // Table vectors streamed back to back with out_ready held high.
    for (int i = 0; i < 16; i++) begin
      b64.in_valid = 1'b1;
      b64.ins      = vecs[i].ins;
      b64.in_tag   = 64'(i + 100);
      b32.in_valid = 1'b1;
      b32.ins      = vecs[i].ins;
      b32.in_tag   = 64'(i + 100);
      @(negedge clk);
      b64.in_valid = 1'b0;
      b32.in_valid = 1'b0;
      e32 = model(vecs[i].ins, 32);
      chk($sformatf("vec%0d_valid", i), 64'(b64.out_valid), 64'd1);
      chk($sformatf("vec%0d_imm", i),   b64.imm,            vecs[i].imm);
      chk($sformatf("vec%0d_fmt", i),   64'(b64.fmt),       64'(vecs[i].fmt));
      chk($sformatf("vec%0d_ill", i),   64'(b64.illegal),   64'(vecs[i].ill));
      chk($sformatf("vec%0d_tag", i),   b64.out_tag,        64'(i + 100));
      chk($sformatf("x32_vec%0d_imm", i), {32'h0, b32.imm}, e32.imm);
      chk($sformatf("x32_vec%0d_fmt", i), 64'(b32.fmt),     64'(e32.fmt));
      chk($sformatf("x32_vec%0d_ill", i), 64'(b32.illegal), 64'(e32.ill));
    end

    // XLEN=32 specific encodings.
    b32.in_valid = 1'b1;
    b32.ins      = 32'h0000001B;
    @(negedge clk);
    b32.in_valid = 1'b0;
    chk("x32_imm32_ill", 64'(b32.illegal), 64'd1);
    chk("x32_imm32_imm", {32'h0, b32.imm}, 64'd0);
    b32.in_valid = 1'b1;
    b32.ins      = 32'h800000B7;
    @(negedge clk);
    b32.in_valid = 1'b0;
    chk("x32_lui_imm", {32'h0, b32.imm}, 64'h0000000080000000);
    chk("x32_lui_fmt", 64'(b32.fmt),     64'd4);
    @(negedge clk);

    // Stall with three back-to-back offers, then release.
    b64.out_ready = 1'b0;
    b64.in_valid  = 1'b1;
    b64.ins       = 32'h00100093;
    b64.in_tag    = 64'd1;
    @(negedge clk);
    chk("stall_ready_after1", 64'(b64.in_ready), 64'd1);
    b64.in_tag = 64'd2;
    @(negedge clk);
    chk("stall_ready_after2", 64'(b64.in_ready), 64'd0);
    chk("stall_head_tag",     b64.out_tag,       64'd1);
    b64.in_tag = 64'd3;
    @(negedge clk);
    chk("stall_hold_tag",     b64.out_tag,       64'd1);
    chk("stall_hold_ready",   64'(b64.in_ready), 64'd0);
    b64.out_ready = 1'b1;
    @(negedge clk);
    chk("drain_tag2",   b64.out_tag,        64'd2);
    chk("drain_ready",  64'(b64.in_ready),  64'd1);
    @(negedge clk);
    b64.in_valid = 1'b0;
    chk("drain_tag3",   b64.out_tag,        64'd3);
    chk("drain_valid3", 64'(b64.out_valid), 64'd1);
    @(negedge clk);
    chk("drain_empty",  64'(b64.out_valid), 64'd0);

    // Flush with both entries full and a same-cycle offer.
    b64.out_ready = 1'b0;
    b64.in_valid  = 1'b1;
    b64.in_tag    = 64'd11;
    @(negedge clk);
    b64.in_tag = 64'd12;
    @(negedge clk);
    chk("flush_pre_full", 64'(b64.in_ready), 64'd0);
    flush      = 1'b1;
    b64.in_tag = 64'd99;
    @(negedge clk);
    flush        = 1'b0;
    b64.in_valid = 1'b0;
    chk("flush_valid", 64'(b64.out_valid), 64'd0);
    chk("flush_ready", 64'(b64.in_ready),  64'd1);
    b64.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_no_ghost", 64'(b64.out_valid), 64'd0);

    // Reset mid-transfer with an offer and a flush in the same cycle.
    b64.out_ready = 1'b0;
    b64.in_valid  = 1'b1;
    b64.ins       = 32'hFFF00093;
    b64.in_tag    = 64'd5;
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    flush        = 1'b0;
    b64.in_valid = 1'b0;
    chk("midrst_valid", 64'(b64.out_valid), 64'd0);
    chk("midrst_ready", 64'(b64.in_ready),  64'd1);
    chk("midrst_imm",   b64.imm,            64'd0);
    chk("midrst_tag",   b64.out_tag,        64'd0);
    b64.out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_stays_empty", 64'(b64.out_valid), 64'd0);

    // Randomized traffic against a depth-2 FIFO model.
    do_reset();
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_out_valid", 64'(b64.out_valid), 64'(q.size() > 0));
      chk("rnd_in_ready",  64'(b64.in_ready),  64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd_imm", b64.imm,          q[0].imm);
        chk("rnd_fmt", 64'(b64.fmt),     64'(q[0].fmt));
        chk("rnd_ill", 64'(b64.illegal), 64'(q[0].ill));
        chk("rnd_tag", b64.out_tag,      q[0].tag);
      end
      b64.in_valid  = ($urandom_range(0, 3) != 0);
      b64.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 40) == 0);
      b64.ins       = $urandom;
      if ($urandom_range(0, 4) != 0)
        b64.ins[6:0] = ops[$urandom_range(0, 12)];
      b64.in_tag = {$urandom, $urandom};
      fire_out = (q.size() > 0) && b64.out_ready;
      fire_in  = b64.in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (fire_out) void'(q.pop_front());
        if (fire_in) begin
          ne     = model(b64.ins, 64);
          ne.tag = b64.in_tag;
          q.push_back(ne);
        end
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
